// File: rtl/gate_exhaustive_tester_if.sv
// Stimulus/response bundle between a gate_exhaustive_tester and its controlling environment.
// master: environment side (start, op_sel, DUT response); slave: the tester itself.
interface gate_exhaustive_tester_if #(
    parameter int N_INPUTS = 2,
    parameter int ERR_W    = 8
);
    logic                start;
    logic [2:0]          op_sel;
    logic                dut_out;
    logic [N_INPUTS-1:0] stim;
    logic                expected;
    logic                busy;
    logic                done;
    logic                pass;
    logic [ERR_W-1:0]    err_count;
    logic [N_INPUTS-1:0] first_fail_vec;

    modport master (
        output start, op_sel, dut_out,
        input  stim, expected, busy, done, pass, err_count, first_fail_vec
    );

    modport slave (
        input  start, op_sel, dut_out,
        output stim, expected, busy, done, pass, err_count, first_fail_vec
    );
endinterface

// File: rtl/gate_exhaustive_tester.sv
// Exhaustive sweep tester for N-input gates with latency-aligned expected values.
// Optional macro GATE_TESTER_STOP_ON_FAIL_EN: end the sweep on the first mismatch.
module gate_exhaustive_tester #(
    parameter int N_INPUTS    = 2,
    parameter int DUT_LATENCY = 0,
    parameter int ERR_W       = 8
) (
    input logic                    clk,
    input logic                    reset,
    gate_exhaustive_tester_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int DCW = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;

    state_t              state, state_nx;
    logic [2:0]          op_q;
    logic [N_INPUTS-1:0] stim_q;
    logic [N_INPUTS-1:0] ffv_q;
    logic [ERR_W-1:0]    err_q;
    logic [DCW-1:0]      drain_cnt;

    logic                head_valid;
    logic                head_exp;
    logic                tail_valid;
    logic                tail_exp;
    logic [N_INPUTS-1:0] tail_vec;
    logic                mismatch;
    logic                stop_fire;
    logic                last_vec;
    logic                drain_end;

    assign head_valid = (state == RUN);
    assign last_vec   = (stim_q == '1);
    assign drain_end  = (drain_cnt == DCW'(DUT_LATENCY - 1));

    always_comb begin
        head_exp = 1'b0;
        case (op_q)
            3'd0:    head_exp = &stim_q;
            3'd1:    head_exp = |stim_q;
            3'd2:    head_exp = ~&stim_q;
            3'd3:    head_exp = ~|stim_q;
            3'd4:    head_exp = ^stim_q;
            3'd5:    head_exp = ~^stim_q;
            default: head_exp = |stim_q;
        endcase
    end

    // Expected/vector travel with a valid bit so compares line up with the DUT's latency.
    generate
        if (DUT_LATENCY == 0) begin : g_comb
            assign tail_valid = head_valid;
            assign tail_exp   = head_exp;
            assign tail_vec   = stim_q;
        end else begin : g_pipe
            localparam int VW = N_INPUTS * DUT_LATENCY;
            logic [DUT_LATENCY-1:0] pv;
            logic [DUT_LATENCY-1:0] pe;
            logic [VW-1:0]          pvec;

            always_ff @(posedge clk) begin
                if (reset || stop_fire) begin
                    pv <= '0;
                end else begin
                    pv <= DUT_LATENCY'({pv, head_valid});
                end
                pe   <= DUT_LATENCY'({pe, head_exp});
                pvec <= VW'({pvec, stim_q});
            end

            assign tail_valid = pv[DUT_LATENCY-1];
            assign tail_exp   = pe[DUT_LATENCY-1];
            assign tail_vec   = pvec[VW-1 -: N_INPUTS];
        end
    endgenerate

    assign mismatch = tail_valid && (bus.dut_out != tail_exp);

`ifdef GATE_TESTER_STOP_ON_FAIL_EN
    assign stop_fire = mismatch;
`else
    assign stop_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = RUN;
            end
            RUN: begin
                if (stop_fire)     state_nx = DONE;
                else if (last_vec) state_nx = (DUT_LATENCY > 0) ? DRAIN : DONE;
            end
            DRAIN: begin
                if (stop_fire || drain_end) state_nx = DONE;
            end
            DONE: begin
                if (bus.start) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            stim_q    <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q      <= bus.op_sel;
                        stim_q    <= '0;
                        err_q     <= '0;
                        ffv_q     <= '0;
                        drain_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!stop_fire && !last_vec) stim_q <= stim_q + 1'b1;
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                default: ;
            endcase
            // Compares only occur in RUN/DRAIN, so they never collide with the start clear.
            if (mismatch) begin
                if (err_q != '1) err_q <= err_q + 1'b1;
                if (err_q == '0) ffv_q <= tail_vec;
            end
        end
    end

    assign bus.stim           = stim_q;
    assign bus.expected       = tail_valid & tail_exp;
    assign bus.busy           = (state == RUN) || (state == DRAIN);
    assign bus.done           = (state == DONE);
    assign bus.pass           = (state == DONE) && (err_q == '0);
    assign bus.err_count      = err_q;
    assign bus.first_fail_vec = ffv_q;

endmodule

// File: doc/gate_exhaustive_tester.md
# gate_exhaustive_tester

Clocked, self-checking exhaustive tester for N-input combinational or pipelined logic gates in the Components_Logic_Gates library. It walks every input vector of an N_INPUTS-wide gate, computes the expected output for a runtime-selected gate function, and compares it against the DUT response after a configurable latency. It counts mismatches and reports pass/fail. It replaces per-gate hand-timed testers with one synthesizable-style sequential block.

## Interface
- N_INPUTS, 2, gate input count (1..8); vectors 0..2^N_INPUTS-1
- DUT_LATENCY, 0, DUT clock cycles from stim to dut_out (0 = combinational DUT)
- ERR_W, 8, mismatch counter width (saturating)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a sweep when in IDLE or DONE
- op_sel  input  3  gate function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 treated as OR
- dut_out  input  1  DUT output
- stim  output  N_INPUTS  registered vector driven to DUT inputs
- expected  output  1  expected value aligned with dut_out being checked
- busy  output  1  high in RUN and DRAIN
- done  output  1  high in DONE
- pass  output  1  valid when done; 1 iff err_count == 0
- err_count  output  ERR_W  mismatches, saturates at 2^ERR_W-1
- first_fail_vec  output  N_INPUTS  stim vector of first mismatch; 0 if none

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: all outputs at reset values. On start, latch op_sel into op_q, clear err_count and first_fail_vec, and go to RUN with stim=0.
- RUN: one vector per cycle. stim increments by 1 each cycle. After stim = 2^N_INPUTS-1, go to DRAIN if DUT_LATENCY>0, otherwise to DONE.
- DRAIN: stays DUT_LATENCY cycles, then goes to DONE. stim holds its last value.
- DONE: done=1 and pass valid. Holds until start, which re-enters RUN with a fresh sweep, or until reset.
- start while busy is ignored. op_sel changes after start are ignored until the next start.
- Expected value: reduction of stim per op_q. Inverting ops use the complement of the AND/OR/XOR reduction.
- Expected and vector pass through a DUT_LATENCY-deep shift pipeline with a valid bit. A compare happens on every cycle where the pipeline-tail valid=1. Exactly 2^N_INPUTS compares occur per sweep.
- Mismatch: dut_out != expected_tail. err_count increments, saturating. On the first mismatch of the sweep, first_fail_vec captures the tail vector.

## Timing
- Reset values: stim=0, expected=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, state IDLE, pipeline valid bits cleared.
- start at edge k: busy=1 and stim=0 after edge k+1. The last vector is driven in cycle k+2^N_INPUTS. done rises after edge k+2^N_INPUTS+DUT_LATENCY+1.
- DUT_LATENCY=0: dut_out is compared in the same cycle stim is driven.
- DUT_LATENCY=L: dut_out is compared L cycles after the corresponding stim. expected shows the aligned value.
- Reset asserted mid-sweep: all state returns to reset values at the next edge and the partial results are discarded. Reset has priority over start.
- Saturation: err_count stays at max. A mismatch on the same cycle as saturation changes nothing else.

## Configuration
- GATE_TESTER_STOP_ON_FAIL_EN defined: on the first mismatch, go directly to DONE on the next edge. stim freezes, the pipeline is flushed invalid, pass=0, err_count=1, and first_fail_vec is captured.
- Undefined: the full sweep always completes and every mismatch is counted.

## Test plan
- N_INPUTS=2, L=0, op_sel=1, DUT = OR of stim -> stim 00,01,10,11 on consecutive cycles; done 5 cycles after start; pass=1, err_count=0.
- Same setup, DUT = AND (faulty) -> err_count=2, first_fail_vec=01, pass=0; with GATE_TESTER_STOP_ON_FAIL_EN, done one cycle after the 01 compare and err_count=1.
- N_INPUTS=3, L=2, op_sel=4, DUT = XOR registered twice -> 8 compares, pass=1; done 11 cycles after start; expected lags stim by 2.
- Reset asserted in cycle 3 of an 8-vector sweep -> next cycle busy=0, stim=0, err_count=0; a new start yields a clean full sweep.
- ERR_W=2, N_INPUTS=3, DUT tied to ~expected -> err_count saturates at 3, first_fail_vec=000, pass=0; start pulses during busy are ignored.
